// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Per-key debouncer and press-event generator for active-low push buttons.
//   Each channel synchronises its raw pin, accepts a level change only after
//   DEBOUNCE_CYCLES consecutive agreeing samples, and produces a clean
//   active-high level plus one-cycle press / release / long-press pulses.
//
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   key_n_in      in   [NUM_KEYS] raw button pins, 0 = pressed
//   key_out       out  [NUM_KEYS] debounced level, 1 = pressed
//   press_pulse   out  [NUM_KEYS] one-cycle pulse on accepted press
//   release_pulse out  [NUM_KEYS] one-cycle pulse on accepted release
//   long_press    out  [NUM_KEYS] one-cycle pulse after LONG_CYCLES held
// -----------------------------------------------------------------------------
module key_debouncer #(
   parameter int NUM_KEYS        = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_n_in,
   output logic [NUM_KEYS-1:0] key_out,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse,
   output logic [NUM_KEYS-1:0] long_press
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      logic              sync1, sync2, raw;
      state_t            state, state_next;
      logic [CNT_W-1:0]  cnt, cnt_next;
      logic [HOLD_W-1:0] hold_cnt, hold_next;
      logic              level, level_next;
      logic              press, press_next;
      logic              rel, rel_next;
      logic              lng, lng_next;
      logic              press_accept, release_accept;

      // Synchroniser output inverted so raw is active-high (1 = pressed).
      assign raw = ~sync2;

      // The sample that completes a check window: current state is a CHK
      // state, the pin still agrees, and this is the last required sample.
      assign press_accept   = (state == PRESS_CHK)   &&  raw && (cnt == CNT_LAST);
      assign release_accept = (state == RELEASE_CHK) && !raw && (cnt == CNT_LAST);

      // State register: synchroniser, FSM, counters and registered outputs.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            state    <= RELEASED;
            cnt      <= '0;
            hold_cnt <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            rel      <= 1'b0;
            lng      <= 1'b0;
         end else begin
            sync1    <= key_n_in[k];
            sync2    <= sync1;
            state    <= state_next;
            cnt      <= cnt_next;
            hold_cnt <= hold_next;
            level    <= level_next;
            press    <= press_next;
            rel      <= rel_next;
            lng      <= lng_next;
         end
      end

      // Next-state logic with the debounce counter.
      always_comb begin
         state_next = state;
         cnt_next   = cnt;
         case (state)
            RELEASED: begin
               if (raw) begin
                  state_next = PRESS_CHK;
                  cnt_next   = CNT_W'(1);
               end else begin
                  cnt_next   = '0;
               end
            end
            PRESS_CHK: begin
               if (!raw) begin
                  state_next = RELEASED;
                  cnt_next   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_next = PRESSED;
                  cnt_next   = '0;
               end else begin
                  cnt_next   = cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!raw) begin
                  state_next = RELEASE_CHK;
                  cnt_next   = CNT_W'(1);
               end
            end
            RELEASE_CHK: begin
               if (raw) begin
                  state_next = PRESSED;
                  cnt_next   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_next = RELEASED;
                  cnt_next   = '0;
               end else begin
                  cnt_next   = cnt + 1'b1;
               end
            end
            default: begin
               state_next = RELEASED;
               cnt_next   = '0;
            end
         endcase
      end

      // Output logic: next values of the registered level, pulses and the
      // hold counter. The hold counter only restarts on a new press so that a
      // rejected release bounce does not reset long-press timing.
      always_comb begin
         level_next = level;
         if (press_accept) begin
            level_next = 1'b1;
         end else if (release_accept) begin
            level_next = 1'b0;
         end
         press_next = press_accept;
         rel_next   = release_accept;

         hold_next  = hold_cnt;
         lng_next   = 1'b0;
         if (press_accept) begin
            hold_next = '0;
         end else if (level && (hold_cnt < HOLD_MAX)) begin
            hold_next = hold_cnt + 1'b1;
            lng_next  = (hold_cnt == HOLD_LAST);
         end
      end

      assign key_out[k]       = level;
      assign press_pulse[k]   = press;
      assign release_pulse[k] = rel;
      assign long_press[k]    = lng;
   end

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
//   Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
//   Inputs change on the falling clock edge; outputs are sampled on the
//   falling edge after each rising edge, so "edge N" below means the Nth
//   rising edge after an input change.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] key_n_in = 2'b11;
   logic [1:0] key_out;
   logic [1:0] press_pulse;
   logic [1:0] release_pulse;
   logic [1:0] long_press;

   int vectors     = 0;
   int miscompares = 0;

   key_debouncer #(
      .NUM_KEYS        (2),
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (10)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_n_in      (key_n_in),
      .key_out       (key_out),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle to the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_all(input string tag, input logic [1:0] ko, input logic [1:0] pp,
                          input logic [1:0] rp, input logic [1:0] lp);
      chk({tag, ".key_out"}, key_out, ko);
      chk({tag, ".press"}, press_pulse, pp);
      chk({tag, ".release"}, release_pulse, rp);
      chk({tag, ".long"}, long_press, lp);
   endtask

   initial begin
      // Reset state
      #2;
      chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      step();
      chk_all("idle", 2'b00, 2'b00, 2'b00, 2'b00);

      // Clean press on key 0: accepted on edge 6
      key_n_in = 2'b10;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all("clean_wait", 2'b00, 2'b00, 2'b00, 2'b00);
      end
      step();                                        // edge 6 = E
      chk_all("clean_accept", 2'b01, 2'b01, 2'b00, 2'b00);
      step();                                        // E+1
      chk_all("clean_pulse_end", 2'b01, 2'b00, 2'b00, 2'b00);

      // Long press: long_press fires exactly at E+10
      for (int i = 2; i <= 9; i++) begin
         step();
         chk("long_early", long_press, 2'b00);
      end
      step();                                        // E+10
      chk_all("long_fire", 2'b01, 2'b00, 2'b00, 2'b01);
      for (int i = 11; i <= 20; i++) begin
         step();
         chk("long_once", long_press, 2'b00);
      end

      // Release after long press: accepted on edge 6 after release
      key_n_in = 2'b11;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all("rel_wait", 2'b01, 2'b00, 2'b00, 2'b00);
      end
      step();
      chk_all("rel_accept", 2'b00, 2'b00, 2'b01, 2'b00);
      step();
      chk_all("rel_pulse_end", 2'b00, 2'b00, 2'b00, 2'b00);
      step();
      step();

      // Bounce: low 3 samples, high 1, then low steady
      key_n_in = 2'b10;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("bounce_low", 2'b00, 2'b00, 2'b00, 2'b00);
      end
      key_n_in = 2'b11;
      step();
      chk_all("bounce_high", 2'b00, 2'b00, 2'b00, 2'b00);
      key_n_in = 2'b10;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all("bounce_wait", 2'b00, 2'b00, 2'b00, 2'b00);
      end
      step();                                        // edge 6 after final fall = E
      chk_all("bounce_accept", 2'b01, 2'b01, 2'b00, 2'b00);

      // Short press: release right away, accepted at E+6, no long_press
      key_n_in = 2'b11;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all("short_wait", 2'b01, 2'b00, 2'b00, 2'b00);
      end
      step();                                        // E+6
      chk_all("short_rel", 2'b00, 2'b00, 2'b01, 2'b00);
      step();
      chk_all("short_rel_end", 2'b00, 2'b00, 2'b00, 2'b00);
      for (int i = 8; i <= 12; i++) begin
         step();
         chk("short_nolong", long_press, 2'b00);
      end

      // Simultaneous press on both keys
      key_n_in = 2'b00;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all("simul_wait", 2'b00, 2'b00, 2'b00, 2'b00);
      end
      step();
      chk_all("simul_accept", 2'b11, 2'b11, 2'b00, 2'b00);
      step();
      chk_all("simul_pulse_end", 2'b11, 2'b00, 2'b00, 2'b00);

      // Reset mid-press: outputs clear immediately, no release pulse
      reset_n  = 1'b0;
      #1;
      chk_all("mid_reset", 2'b00, 2'b00, 2'b00, 2'b00);
      key_n_in = 2'b10;                              // key 0 still held, key 1 let go
      step();
      chk_all("in_reset", 2'b00, 2'b00, 2'b00, 2'b00);
      reset_n  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_all("post_reset_wait", 2'b00, 2'b00, 2'b00, 2'b00);
      end
      step();                                        // edge 6 after reset release
      chk_all("post_reset_accept", 2'b01, 2'b01, 2'b00, 2'b00);
      step();
      chk_all("post_reset_end", 2'b01, 2'b00, 2'b00, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
